// File: rtl/dsa_simd_pkg.sv
// Shared constants and state encoding for the SIMD interpolate/writeback stage.
package dsa_simd_pkg;
    localparam int SIMD_WIDTH_DEF = 4;
    localparam int PIX_W          = 8;
    localparam int FRAC_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_WRITE,
        ST_DONE
    } state_t;
endpackage

// File: rtl/dsa_bilinear_lane.sv
// Combinational bilinear blend of four Q0.8-weighted neighbours into one 8-bit pixel.
module dsa_bilinear_lane
    import dsa_simd_pkg::*;
#(
    parameter int ROUND = 1
) (
    input  logic [PIX_W-1:0]  p00,
    input  logic [PIX_W-1:0]  p01,
    input  logic [PIX_W-1:0]  p10,
    input  logic [PIX_W-1:0]  p11,
    input  logic [FRAC_W-1:0] a,
    input  logic [FRAC_W-1:0] b,
    output logic [PIX_W-1:0]  r
);
    logic [8:0]  inv_a;
    logic [8:0]  inv_b;
    logic [16:0] top;
    logic [16:0] bot;
    logic [24:0] v;
    logic [25:0] v_rnd;
    logic [9:0]  r_wide;

    // Horizontal blend of both rows, then vertical blend; widths leave headroom so nothing wraps.
    always_comb begin
        inv_a  = 9'd256 - {1'b0, a};
        inv_b  = 9'd256 - {1'b0, b};
        top    = 17'(p00) * 17'(inv_a) + 17'(p01) * 17'(a);
        bot    = 17'(p10) * 17'(inv_a) + 17'(p11) * 17'(a);
        v      = 25'(top) * 25'(inv_b) + 25'(bot) * 25'(b);
        v_rnd  = {1'b0, v} + ((ROUND != 0) ? 26'd32768 : 26'd0);
        r_wide = v_rnd[25:16];
        r      = (r_wide > 10'd255) ? 8'hFF : r_wide[7:0];
    end
endmodule

// File: rtl/dsa_interp_writeback_simd.sv
// Accepts one SIMD group, interpolates one lane per cycle, then writes one byte per cycle.
module dsa_interp_writeback_simd
    import dsa_simd_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int SIMD_WIDTH = SIMD_WIDTH_DEF,
    parameter int ROUND      = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIX_W*SIMD_WIDTH-1:0]  p00,
    input  logic [PIX_W*SIMD_WIDTH-1:0]  p01,
    input  logic [PIX_W*SIMD_WIDTH-1:0]  p10,
    input  logic [PIX_W*SIMD_WIDTH-1:0]  p11,
    input  logic [16*SIMD_WIDTH-1:0]     a,
    input  logic [16*SIMD_WIDTH-1:0]     b,
    input  logic [15:0]                  dst_x,
    input  logic [15:0]                  dst_y,
    input  logic [ADDR_WIDTH-1:0]        out_base_addr,
    input  logic [15:0]                  out_width,
    input  logic [15:0]                  out_height,
    output logic                         mem_write_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [7:0]                   mem_wdata,
    output logic                         done,
    output logic                         busy
);
    localparam int LANE_W = (SIMD_WIDTH > 1) ? $clog2(SIMD_WIDTH) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SIMD_WIDTH - 1);

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;

    logic [PIX_W-1:0]    pix00_q [SIMD_WIDTH];
    logic [PIX_W-1:0]    pix01_q [SIMD_WIDTH];
    logic [PIX_W-1:0]    pix10_q [SIMD_WIDTH];
    logic [PIX_W-1:0]    pix11_q [SIMD_WIDTH];
    logic [FRAC_W-1:0]   fa_q    [SIMD_WIDTH];
    logic [FRAC_W-1:0]   fb_q    [SIMD_WIDTH];
    logic [PIX_W-1:0]    result_q[SIMD_WIDTH];
    logic [15:0]         dst_x_q, dst_y_q, width_q, height_q;
    logic [ADDR_WIDTH-1:0] base_q;

    logic                accept;
    logic [PIX_W-1:0]    lane_r;
    logic                wr_en_d, done_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [7:0]          wdata_d;
    logic [47:0]         addr_sum;
    logic                unused_frac_hi;

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = in_valid && in_ready;

    // Only the low byte of each fraction carries Q0.8 weight.
    always_comb begin
        unused_frac_hi = 1'b0;
        for (int k = 0; k < SIMD_WIDTH; k++)
            unused_frac_hi = unused_frac_hi ^ (^a[k*16+8 +: 8]) ^ (^b[k*16+8 +: 8]);
    end

    dsa_bilinear_lane #(.ROUND(ROUND)) u_lane (
        .p00 (pix00_q[lane_q]),
        .p01 (pix01_q[lane_q]),
        .p10 (pix10_q[lane_q]),
        .p11 (pix11_q[lane_q]),
        .a   (fa_q[lane_q]),
        .b   (fb_q[lane_q]),
        .r   (lane_r)
    );

    // State and lane index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // Next-state: walk lanes through compute, then through write slots.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_COMPUTE;
                lane_d  = '0;
            end
            ST_COMPUTE: begin
                if (lane_q == LAST_LANE) begin
                    state_d = ST_WRITE;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (lane_q == LAST_LANE) begin
                    state_d = ST_DONE;
                    lane_d  = '0;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming slot so the write port is registered.
    always_comb begin
        addr_sum = 48'(base_q) + 48'(dst_y_q) * 48'(width_q) + 48'(dst_x_q) + 48'(lane_d);
        wr_en_d  = 1'b0;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        done_d   = (state_d == ST_DONE);
        if (state_d == ST_WRITE) begin
            addr_d  = addr_sum[ADDR_WIDTH-1:0];
            wdata_d = result_q[lane_d];
            wr_en_d = (({1'b0, dst_x_q} + 17'(lane_d)) < {1'b0, width_q}) &&
                      (dst_y_q < height_q);
        end
    end

    // Registered write port and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            done         <= 1'b0;
        end else begin
            mem_write_en <= wr_en_d;
            mem_addr     <= addr_d;
            mem_wdata    <= wdata_d;
            done         <= done_d;
        end
    end

    // Capture the group on accept; store one interpolated lane per compute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SIMD_WIDTH; k++) begin
                pix00_q[k]  <= '0;
                pix01_q[k]  <= '0;
                pix10_q[k]  <= '0;
                pix11_q[k]  <= '0;
                fa_q[k]     <= '0;
                fb_q[k]     <= '0;
                result_q[k] <= '0;
            end
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            base_q   <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < SIMD_WIDTH; k++) begin
                    pix00_q[k] <= p00[k*PIX_W +: PIX_W];
                    pix01_q[k] <= p01[k*PIX_W +: PIX_W];
                    pix10_q[k] <= p10[k*PIX_W +: PIX_W];
                    pix11_q[k] <= p11[k*PIX_W +: PIX_W];
                    fa_q[k]    <= a[k*16 +: FRAC_W];
                    fb_q[k]    <= b[k*16 +: FRAC_W];
                end
                dst_x_q  <= dst_x;
                dst_y_q  <= dst_y;
                width_q  <= out_width;
                height_q <= out_height;
                base_q   <= out_base_addr;
            end
            if (state_q == ST_COMPUTE)
                result_q[lane_q] <= lane_r;
        end
    end
endmodule

// File: tb/tb_dsa_interp_writeback_simd.sv
// Randomized and directed bench for dsa_interp_writeback_simd, rounding and truncating builds.
module tb_dsa_interp_writeback_simd;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] p00, p01, p10, p11;
    logic [63:0] a, b;
    logic [15:0] dst_x, dst_y, out_width, out_height;
    logic [17:0] out_base_addr;

    logic        in_ready, mem_write_en, done, busy;
    logic [17:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        t_in_ready, t_mem_write_en, t_done, t_busy;
    logic [17:0] t_mem_addr;
    logic [7:0]  t_mem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  g00[4], g01[4], g10[4], g11[4], ga[4], gb[4];

    always #5 clk = ~clk;

    dsa_interp_writeback_simd #(.ADDR_WIDTH(18), .SIMD_WIDTH(4), .ROUND(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11), .a(a), .b(b),
        .dst_x(dst_x), .dst_y(dst_y), .out_base_addr(out_base_addr),
        .out_width(out_width), .out_height(out_height),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .busy(busy)
    );

    dsa_interp_writeback_simd #(.ADDR_WIDTH(18), .SIMD_WIDTH(4), .ROUND(0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11), .a(a), .b(b),
        .dst_x(dst_x), .dst_y(dst_y), .out_base_addr(out_base_addr),
        .out_width(out_width), .out_height(out_height),
        .mem_write_en(t_mem_write_en), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .done(t_done), .busy(t_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expanded four-term weighted sum of the neighbours.
    function automatic int bilerp(int q00, int q01, int q10, int q11, int fa, int fb, bit rnd);
        longint v;
        v = longint'(q00) * (256 - fa) * (256 - fb) + longint'(q01) * fa * (256 - fb)
          + longint'(q10) * (256 - fa) * fb + longint'(q11) * fa * fb;
        if (rnd) v = v + 32768;
        v = v / 65536;
        if (v > 255) v = 255;
        return int'(v);
    endfunction

    task automatic apply_group();
        for (int k = 0; k < 4; k++) begin
            p00[k*8 +: 8]  = g00[k];
            p01[k*8 +: 8]  = g01[k];
            p10[k*8 +: 8]  = g10[k];
            p11[k*8 +: 8]  = g11[k];
            a[k*16 +: 16]  = {8'($urandom), ga[k]};
            b[k*16 +: 16]  = {8'($urandom), gb[k]};
        end
    endtask

    task automatic set_uniform(input int v00, input int v01, input int v10, input int v11,
                               input int fa, input int fb);
        for (int k = 0; k < 4; k++) begin
            g00[k] = 8'(v00); g01[k] = 8'(v01); g10[k] = 8'(v10); g11[k] = 8'(v11);
            ga[k] = 8'(fa); gb[k] = 8'(fb);
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < 4; k++) begin
            g00[k] = 8'($urandom); g01[k] = 8'($urandom);
            g10[k] = 8'($urandom); g11[k] = 8'($urandom);
            ga[k]  = 8'($urandom); gb[k]  = 8'($urandom);
        end
        out_width     = 16'($urandom_range(1, 64));
        out_height    = 16'($urandom_range(1, 64));
        dst_x         = 16'($urandom_range(0, 70));
        dst_y         = 16'($urandom_range(0, 70));
        out_base_addr = 18'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            out_width  = 16'hFFFF;
            out_height = 16'hFFFF;
            dst_x      = 16'hFFFE;
            dst_y      = 16'($urandom);
        end
    endtask

    // Runs one group from accept to ready; hold keeps in_valid asserted while busy.
    // abort_at > 0 pulls reset just after that cycle's checks.
    task automatic do_group(input bit hold, input int abort_at, output int waited);
        bit          exp_en[4];
        logic [17:0] exp_addr[4];
        int          exp_r1[4], exp_r0[4];
        int          k;
        apply_group();
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            exp_r1[i]   = bilerp(g00[i], g01[i], g10[i], g11[i], ga[i], gb[i], 1'b1);
            exp_r0[i]   = bilerp(g00[i], g01[i], g10[i], g11[i], ga[i], gb[i], 1'b0);
            exp_en[i]   = (int'(dst_x) + i < int'(out_width)) && (dst_y < out_height);
            exp_addr[i] = 18'(longint'(out_base_addr) + longint'(dst_y) * out_width
                              + dst_x + i);
        end
        @(posedge clk);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) begin
                p00 = $urandom; p01 = $urandom; p10 = $urandom; p11 = $urandom;
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                dst_x = 16'($urandom); dst_y = 16'($urandom);
                out_width = 16'($urandom); out_height = 16'($urandom);
                out_base_addr = 18'($urandom);
                if (!hold) in_valid = 1'b0;
            end
            check("busy", busy, j <= 9);
            check("in_ready", in_ready, j == 10);
            check("done", done, j == 9);
            check("done_trunc", t_done, j == 9);
            if (j >= 5 && j <= 8) begin
                k = j - 5;
                check("wr_en", mem_write_en, exp_en[k]);
                check("wr_en_trunc", t_mem_write_en, exp_en[k]);
                if (exp_en[k]) begin
                    check("wr_addr", mem_addr, exp_addr[k]);
                    check("wr_data_round", mem_wdata, exp_r1[k]);
                    check("wr_data_trunc", t_mem_wdata, exp_r0[k]);
                end
            end else begin
                check("wr_en_idle", mem_write_en, 0);
            end
            if (j == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                in_valid = 1'b0;
                check("rst_wr_en", mem_write_en, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_wdata", mem_wdata, 0);
                check("rst_done", done, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", in_ready, 1);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int m = 0; m < 12; m++) begin
                    @(negedge clk);
                    check("post_rst_wr_en", mem_write_en, 0);
                    check("post_rst_done", done, 0);
                end
                return;
            end
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        in_valid = 1'b0;
        set_uniform(0, 0, 0, 0, 0, 0);
        apply_group();
        dst_x = 0; dst_y = 0; out_width = 1; out_height = 1; out_base_addr = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_wr_en", mem_write_en, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity: a=b=0 returns p00.
        set_uniform(0, 77, 88, 99, 0, 0);
        g00[0] = 10; g00[1] = 20; g00[2] = 30; g00[3] = 40;
        out_base_addr = 18'h100; out_width = 64; out_height = 16; dst_x = 0; dst_y = 2;
        do_group(1'b0, 0, w);
        @(negedge clk);

        // Horizontal midpoint, vertical midpoint, corner saturation.
        set_uniform(0, 255, 0, 255, 128, 0);
        out_base_addr = 18'h3_0000; out_width = 100; out_height = 100; dst_x = 5; dst_y = 7;
        do_group(1'b0, 0, w);
        set_uniform(100, 13, 200, 211, 0, 128);
        do_group(1'b0, 0, w);
        set_uniform(255, 255, 255, 255, 255, 255);
        do_group(1'b0, 0, w);

        // Right edge and bottom edge.
        set_random();
        out_base_addr = 18'h200; out_width = 10; out_height = 5; dst_x = 8; dst_y = 0;
        do_group(1'b0, 0, w);
        set_random();
        out_width = 10; out_height = 5; dst_x = 0; dst_y = 5;
        do_group(1'b0, 0, w);

        // Back-to-back with in_valid held: second group must be taken immediately at ready.
        set_random();
        do_group(1'b1, 0, w);
        set_random();
        do_group(1'b1, 0, w);
        check("b2b_wait", w, 0);
        set_random();
        do_group(1'b0, 0, w);
        check("b2b_wait2", w, 0);

        // Reset after two write slots, then a normal group.
        set_random();
        out_width = 64; out_height = 64; dst_x = 0; dst_y = 1;
        do_group(1'b0, 6, w);
        set_random();
        do_group(1'b0, 0, w);

        for (int i = 0; i < 30; i++) begin
            set_random();
            do_group(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 0, w);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
